clock_set_controller: RTL

- Sequences the time-setting datapath of the clock: selects which counter group runs, generates increment pulses for the Up button (single step plus hold-to-repeat), and drives the blink masks for the display.
- Returns to run mode automatically after an inactivity timeout.
- Sits between the debounced buttons, the clock master tick and the clock counters / display, in place of the simple set-mode sequencer.

---
 rtl/clock_set_controller_if.sv | 37 +++
 rtl/clock_set_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller_if.sv
// Button/tick inputs and counter/display controls of the time-setting sequencer.
// The controller takes the slave view; the producer of ticks and buttons takes the master view.
interface clock_set_controller_if;
  logic       i_Tick;
  logic       i_Button_Set_Pulse;
  logic       i_Button_Up_Level;
  logic       o_Counters_Reset;
  logic       o_Enable_Increment;
  logic [2:0] o_Counters_Enable_Count;
  logic [1:0] o_Display_Enable_Digits;
  logic       o_Display_Enable_Dot;
  logic [1:0] o_Mode;

  modport master (
    output i_Tick,
    output i_Button_Set_Pulse,
    output i_Button_Up_Level,
    input  o_Counters_Reset,
    input  o_Enable_Increment,
    input  o_Counters_Enable_Count,
    input  o_Display_Enable_Digits,
    input  o_Display_Enable_Dot,
    input  o_Mode
  );

  modport slave (
    input  i_Tick,
    input  i_Button_Set_Pulse,
    input  i_Button_Up_Level,
    output o_Counters_Reset,
    output o_Enable_Increment,
    output o_Counters_Enable_Count,
    output o_Display_Enable_Digits,
    output o_Display_Enable_Dot,
    output o_Mode
  );
endinterface

// File: rtl/clock_set_controller.sv
// Time-setting sequencer: mode select, Up single-step plus hold-to-repeat, blink masks, inactivity timeout.
// Latency: all outputs registered, one cycle after the sampled event; no backpressure, inputs are strobes/levels.
module clock_set_controller #(
  parameter int unsigned REPEAT_DELAY  = 512,
  parameter int unsigned REPEAT_RATE   = 128,
  parameter int unsigned TIMEOUT_TICKS = 10240
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  clock_set_controller_if.slave bus
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int          RPT_W   = $clog2(RPT_MAX + 1);
  localparam int          TO_W    = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [RPT_W-1:0] DELAY_CMP = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RATE_CMP  = RPT_W'(REPEAT_RATE);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  mode_e            state;
  mode_e            state_next;
  logic             up_prev;
  logic             arm;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_phase;
  logic [TO_W-1:0]  to_cnt;

  logic             counters_reset_q;
  logic             enable_increment_q;
  logic [2:0]       count_en_q;
  logic [1:0]       digits_q;
  logic             dot_q;

  logic             tick;
  logic             set_pulse;
  logic             up;
  logic             in_set;
  logic             up_rise;
  logic             hold_ok;
  logic             timeout_hit;
  logic             state_change;
  logic [RPT_W-1:0] rpt_inc;
  logic [RPT_W-1:0] rpt_thr;
  logic             rpt_hit;
  logic             inc_next;
  logic             counters_reset_next;
  logic [2:0]       count_en_next;
  logic [1:0]       digits_next;
  logic             dot_next;

  assign tick      = bus.i_Tick;
  assign set_pulse = bus.i_Button_Set_Pulse;
  assign up        = bus.i_Button_Up_Level;

  always_comb begin
    in_set      = (state == SET_HOUR) || (state == SET_MIN);
    up_rise     = up & ~up_prev;
    // A hold only counts when Up was seen released in this mode (arm), so a
    // press carried across a mode change never increments the new counter.
    hold_ok     = in_set & ~set_pulse & up & arm;
    timeout_hit = in_set & ~set_pulse & ~up & tick & (to_cnt == TO_LAST);
    rpt_inc     = rpt_cnt + RPT_W'(1);
    rpt_thr     = rpt_phase ? RATE_CMP : DELAY_CMP;
    rpt_hit     = hold_ok & ~up_rise & tick & (rpt_inc == rpt_thr);
    inc_next    = ((hold_ok & up_rise) | rpt_hit) & ~enable_increment_q;
    counters_reset_next = (state == SET_MIN) & set_pulse;
  end

  always_comb begin
    state_next = RUN;
    case (state)
      RUN:      state_next = set_pulse ? SET_HOUR : RUN;
      SET_HOUR: state_next = set_pulse ? SET_MIN  : SET_HOUR;
      SET_MIN:  state_next = set_pulse ? RUN      : SET_MIN;
      default:  state_next = RUN;
    endcase
    if (timeout_hit) begin
      state_next = RUN;
    end
    state_change = (state_next != state);
  end

  always_comb begin
    count_en_next = 3'b001;
    digits_next   = 2'b00;
    dot_next      = 1'b1;
    case (state_next)
      SET_HOUR: begin
        count_en_next = 3'b100;
        digits_next   = 2'b10;
        dot_next      = 1'b0;
      end
      SET_MIN: begin
        count_en_next = 3'b010;
        digits_next   = 2'b01;
        dot_next      = 1'b0;
      end
      default: begin
        count_en_next = 3'b001;
        digits_next   = 2'b00;
        dot_next      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state              <= RUN;
      counters_reset_q   <= 1'b0;
      enable_increment_q <= 1'b0;
      count_en_q         <= 3'b001;
      digits_q           <= 2'b00;
      dot_q              <= 1'b1;
    end else begin
      state              <= state_next;
      counters_reset_q   <= counters_reset_next;
      enable_increment_q <= inc_next;
      count_en_q         <= count_en_next;
      digits_q           <= digits_next;
      dot_q              <= dot_next;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      up_prev <= 1'b0;
      arm     <= 1'b0;
    end else begin
      up_prev <= up;
      if (state_change) begin
        arm <= 1'b0;
      end else if (!up) begin
        arm <= 1'b1;
      end
    end
  end

  // Repeat counter measures ticks toward the first pulse (REPEAT_DELAY), then
  // restarts and measures the gap between later pulses (REPEAT_RATE).
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (!hold_ok || up_rise || state_change) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (tick) begin
      if (rpt_inc == rpt_thr) begin
        rpt_cnt   <= '0;
        rpt_phase <= 1'b1;
      end else begin
        rpt_cnt   <= rpt_inc;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      to_cnt <= '0;
    end else if (!in_set || set_pulse || up || state_change) begin
      to_cnt <= '0;
    end else if (tick) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign bus.o_Mode                  = state;
  assign bus.o_Counters_Reset        = counters_reset_q;
  assign bus.o_Enable_Increment      = enable_increment_q;
  assign bus.o_Counters_Enable_Count = count_en_q;
  assign bus.o_Display_Enable_Digits = digits_q;
  assign bus.o_Display_Enable_Dot    = dot_q;

endmodule
